// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: stalls the core while computing,
// then pulses o_done for one cycle so writeback can take o_result.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic            i_flush,
    output logic            o_stall,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CALC   = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state;
    logic [2:0]        f3;
    logic [XLEN-1:0]   b_mag;
    logic [2*XLEN-1:0] acc;
    logic              neg;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   result;

    // Operand decode in the issuing cycle
    logic            signed_a, signed_b, sa, sb, neg_in;
    logic            is_div, div_zero, ovf, fast;
    logic [XLEN-1:0] a_abs, b_abs, fast_res;

    always_comb begin
        is_div   = i_funct3[2];
        signed_b = (i_funct3[2:1] == 2'b00) | (i_funct3[2] & ~i_funct3[0]);
        signed_a = signed_b | (i_funct3 == 3'b010);
        sa       = signed_a & i_rs1_data[XLEN-1];
        sb       = signed_b & i_rs2_data[XLEN-1];
        a_abs    = sa ? -i_rs1_data : i_rs1_data;
        b_abs    = sb ? -i_rs2_data : i_rs2_data;
        // Remainder takes the dividend's sign; everything else the xor
        neg_in   = (is_div & i_funct3[1]) ? sa : (sa ^ sb);
        div_zero = is_div & (i_rs2_data == '0);
        ovf      = is_div & ~i_funct3[0] & (i_rs1_data == MIN_NEG) & (i_rs2_data == '1);
        fast     = div_zero | ovf;
        if (div_zero)
            fast_res = i_funct3[1] ? i_rs1_data : '1;
        else
            fast_res = i_funct3[1] ? '0 : MIN_NEG;
    end

    // One iteration of shift-add (multiply) or restoring subtract (divide)
    logic [XLEN:0]     mul_sum, div_hi, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] acc_next;

    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag} : '0);
        div_hi   = acc[2*XLEN-1:XLEN-1];
        div_diff = div_hi - {1'b0, b_mag};
        div_ge   = ~div_diff[XLEN];
        if (f3[2])
            acc_next = {(div_ge ? div_diff[XLEN-1:0] : div_hi[XLEN-1:0]), acc[XLEN-2:0], div_ge};
        else
            acc_next = {mul_sum, acc[XLEN-1:1]};
    end

    // Sign correction applied in FINISH
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   dsel, fin_res;

    always_comb begin
        prod = neg ? -acc : acc;
        dsel = f3[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
        if (f3[2])
            fin_res = neg ? -dsel : dsel;
        else if (f3 == 3'b000)
            fin_res = prod[XLEN-1:0];
        else
            fin_res = prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= S_IDLE;
            f3     <= '0;
            b_mag  <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            cnt    <= '0;
            result <= '0;
        end else if (i_flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (i_start) begin
                    f3  <= i_funct3;
                    neg <= neg_in;
                    if (fast) begin
                        result <= fast_res;
                        state  <= S_DONE;
                    end else begin
                        acc   <= {{XLEN{1'b0}}, a_abs};
                        b_mag <= b_abs;
                        cnt   <= CW'(XLEN);
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc <= acc_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= S_FINISH;
                end
                S_FINISH: begin
                    result <= fin_res;
                    state  <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_stall  = ((state == S_IDLE) & i_start) | (state == S_CALC) | (state == S_FINISH);
    assign o_busy   = (state != S_IDLE);
    assign o_done   = (state == S_DONE);
    assign o_result = result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, results, fast path, flush, reset.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic        flush = 1'b0;
    logic        stall, busy, done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    muldiv_sequencer #(.XLEN(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_funct3(funct3),
        .i_rs1_data(rs1), .i_rs2_data(rs2), .i_flush(flush),
        .o_stall(stall), .o_busy(busy), .o_done(done), .o_result(result)
    );

    always #5 clk = ~clk;

    // Issue one op with i_start held until DONE; operands are scrambled after acceptance
    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [31:0] exp_res);
        int cyc;
        bit got, stall_bad;
        @(negedge clk);
        funct3 = f; rs1 = a; rs2 = b; start = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL %s issue_stall got %b want 1", name, stall);
        end
        cyc = 0; got = 0; stall_bad = 0;
        while (cyc < 40 && !got) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin rs1 = ~a; rs2 = ~b; end
            if (done === 1'b1) got = 1;
            else if (stall !== 1'b1) stall_bad = 1;
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL %s timeout got no done want done at %0d", name, lat);
        end
        checks++;
        if (cyc != lat) begin
            errors++; $display("FAIL %s latency got %0d want %0d", name, cyc, lat);
        end
        checks++;
        if (result !== exp_res) begin
            errors++; $display("FAIL %s result got %h want %h", name, result, exp_res);
        end
        checks++;
        if (stall_bad || stall !== 1'b0) begin
            errors++; $display("FAIL %s stall_profile got bad=%0d done_stall=%b want 0/0", name, stall_bad, stall);
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL %s after_done got busy=%b done=%b want 0 0", name, busy, done);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset got busy=%b done=%b result=%h stall=%b want 0 0 0 0", busy, done, result, stall);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        run_op("mul_7x6", 3'b000, 32'd7, 32'd6, 34, 32'd42);
        run_op("mul_neg", 3'b000, 32'hFFFF_FFFD, 32'd5, 34, 32'hFFFF_FFF1);
        run_op("mulh", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'h0000_0000);
        run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFE);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFF);
    endtask

    task automatic test_div();
        run_op("div", 3'b100, 32'd20, 32'hFFFF_FFFD, 34, 32'hFFFF_FFFA);
        run_op("rem", 3'b110, 32'd20, 32'hFFFF_FFFD, 34, 32'h0000_0002);
        run_op("divu", 3'b101, 32'd20, 32'hFFFF_FFFD, 34, 32'h0000_0000);
        run_op("remu", 3'b111, 32'd20, 32'hFFFF_FFFD, 34, 32'h0000_0014);
        run_op("rem_negdividend", 3'b110, 32'hFFFF_FFEC, 32'd3, 34, 32'hFFFF_FFFE);
    endtask

    task automatic test_edges();
        run_op("divu_by0", 3'b101, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
        run_op("rem_by0", 3'b110, 32'd5, 32'd0, 1, 32'd5);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000);
    endtask

    task automatic test_flush();
        logic [31:0] prev;
        prev = 32'h0000_0000;  // rem_ovf result left in o_result
        @(negedge clk);
        funct3 = 3'b100; rs1 = 32'd1000; rs2 = 32'd7; start = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0 || result !== prev) begin
            errors++;
            $display("FAIL flush got busy=%b done=%b stall=%b result=%h want 0 0 0 %h",
                     busy, done, stall, result, prev);
        end
        @(negedge clk);
        flush = 1'b0;
        run_op("div_after_flush", 3'b100, 32'd100, 32'd7, 34, 32'd14);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        funct3 = 3'b000; rs1 = 32'h1234; rs2 = 32'h10; start = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL async_reset got busy=%b done=%b result=%h want 0 0 0", busy, done, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op("mul_after_reset", 3'b000, 32'd3, 32'd5, 34, 32'd15);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_edges();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
